// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 ping-pong transpose buffer.
package dct_pkg;

  localparam int DCT_N     = 8;
  localparam int DCT_W     = 8;
  localparam int DCT_IDX_W = $clog2(DCT_N);

  localparam logic [DCT_IDX_W-1:0] DCT_LAST = DCT_IDX_W'(DCT_N - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_st_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_st_t;

endpackage

// File: rtl/dct_tp_bank.sv
// One ping-pong bank: 8x8 sample array, one row written per edge, one column
// read combinationally. Contents are deliberately left unreset.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int W = DCT_W
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [DCT_IDX_W-1:0]         wr_row,
  input  logic [DCT_N-1:0][W-1:0]      wr_dat,
  input  logic [DCT_IDX_W-1:0]         rd_col,
  output logic [DCT_N-1:0][W-1:0]      rd_dat
);

  logic [DCT_N-1:0][DCT_N-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_dat;
    end
  end

  // Column k gathers element k of every stored row.
  always_comb begin
    for (int j = 0; j < DCT_N; j++) begin
      rd_dat[j] = mem[j][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// 8x8 block transposer with two ping-pong banks; first column 1 cycle after row 7, no backpressure
// (rows hitting a busy bank are dropped). Optional sticky drop flag o_ovf under DCT_TRANSPOSE_OVF_EN.
module dct_transpose
  import dct_pkg::*;
#(
  parameter int W = DCT_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                i_stb,
  input  logic signed [W-1:0] i_D0,
  input  logic signed [W-1:0] i_D1,
  input  logic signed [W-1:0] i_D2,
  input  logic signed [W-1:0] i_D3,
  input  logic signed [W-1:0] i_D4,
  input  logic signed [W-1:0] i_D5,
  input  logic signed [W-1:0] i_D6,
  input  logic signed [W-1:0] i_D7,
  output logic                o_stb,
  output logic signed [W-1:0] o_D0,
  output logic signed [W-1:0] o_D1,
  output logic signed [W-1:0] o_D2,
  output logic signed [W-1:0] o_D3,
  output logic signed [W-1:0] o_D4,
  output logic signed [W-1:0] o_D5,
  output logic signed [W-1:0] o_D6,
  output logic signed [W-1:0] o_D7
`ifdef DCT_TRANSPOSE_OVF_EN
  ,
  output logic                o_ovf
`endif
);

  logic [DCT_N-1:0][W-1:0] row_dat;
  logic [DCT_N-1:0][W-1:0] out_dat;
  logic [DCT_N-1:0][W-1:0] bank_col [2];

  bank_st_t               bank_st     [2];
  bank_st_t               bank_st_nxt [2];
  logic                   wr_bank;
  logic [DCT_IDX_W-1:0]   wr_row;
  logic                   accept;
  logic [1:0]             wr_en;

  rd_st_t                 rd_st;
  rd_st_t                 rd_st_nxt;
  logic                   rd_bank;
  logic                   rd_bank_nxt;
  logic [DCT_IDX_W-1:0]   rd_col;
  logic [DCT_IDX_W-1:0]   rd_col_nxt;
  logic                   col_vld;
  logic [DCT_IDX_W-1:0]   col_sel;
  logic                   rd_done;

  assign row_dat[0] = i_D0;
  assign row_dat[1] = i_D1;
  assign row_dat[2] = i_D2;
  assign row_dat[3] = i_D3;
  assign row_dat[4] = i_D4;
  assign row_dat[5] = i_D5;
  assign row_dat[6] = i_D6;
  assign row_dat[7] = i_D7;

  assign o_D0 = out_dat[0];
  assign o_D1 = out_dat[1];
  assign o_D2 = out_dat[2];
  assign o_D3 = out_dat[3];
  assign o_D4 = out_dat[4];
  assign o_D5 = out_dat[5];
  assign o_D6 = out_dat[6];
  assign o_D7 = out_dat[7];

  // A bank that is FULL or being read cannot take rows; such rows are lost.
  assign accept = i_stb && (bank_st[wr_bank] == BANK_EMPTY ||
                            bank_st[wr_bank] == BANK_FILLING);
  assign wr_en  = {accept & wr_bank, accept & ~wr_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(.W(W)) u_bank (
      .clk    (CLK),
      .wr_en  (wr_en[b]),
      .wr_row (wr_row),
      .wr_dat (row_dat),
      .rd_col (col_sel),
      .rd_dat (bank_col[b])
    );
  end

  // Writer and reader never own the same bank, so both updates can merge here.
  always_comb begin
    bank_st_nxt = bank_st;
    if (accept) begin
      bank_st_nxt[wr_bank] = (wr_row == DCT_LAST) ? BANK_FULL : BANK_FILLING;
    end
    if (col_vld) begin
      bank_st_nxt[rd_bank] = rd_done ? BANK_EMPTY : BANK_READING;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      wr_row     <= '0;
    end else begin
      bank_st <= bank_st_nxt;
      if (accept) begin
        wr_row <= wr_row + DCT_IDX_W'(1);
        if (wr_row == DCT_LAST) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_st   <= RD_IDLE;
      rd_col  <= '0;
      rd_bank <= 1'b0;
    end else begin
      rd_st   <= rd_st_nxt;
      rd_col  <= rd_col_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // IDLE already emits column 0 on the edge it sees FULL, giving 1-cycle latency.
  always_comb begin
    rd_st_nxt   = rd_st;
    rd_col_nxt  = rd_col;
    rd_bank_nxt = rd_bank;
    case (rd_st)
      RD_IDLE: begin
        if (col_vld) begin
          rd_st_nxt  = RD_READ;
          rd_col_nxt = DCT_IDX_W'(1);
        end
      end
      RD_READ: begin
        rd_col_nxt = rd_col + DCT_IDX_W'(1);
        if (rd_done) begin
          rd_bank_nxt = ~rd_bank;
          if (bank_st[~rd_bank] != BANK_FULL) begin
            rd_st_nxt = RD_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    col_vld = 1'b0;
    col_sel = rd_col;
    rd_done = 1'b0;
    case (rd_st)
      RD_IDLE: begin
        col_vld = (bank_st[rd_bank] == BANK_FULL);
        col_sel = '0;
      end
      RD_READ: begin
        col_vld = 1'b1;
        rd_done = (rd_col == DCT_LAST);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_stb   <= 1'b0;
      out_dat <= '0;
    end else begin
      o_stb <= col_vld;
      if (col_vld) begin
        out_dat <= bank_col[rd_bank];
      end
    end
  end

`ifdef DCT_TRANSPOSE_OVF_EN
  logic drop;
  assign drop = i_stb & ~accept;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_ovf <= 1'b0;
    end else if (drop) begin
      o_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_transpose.sv
// Directed bench for dct_transpose: single block, streaming, gapped extremes, mid-block reset.
module tb_dct_transpose;

  logic              clk;
  logic              rst_n;
  logic              i_stb;
  logic signed [7:0] i_D0, i_D1, i_D2, i_D3, i_D4, i_D5, i_D6, i_D7;
  logic              o_stb;
  logic signed [7:0] o_D0, o_D1, o_D2, o_D3, o_D4, o_D5, o_D6, o_D7;
`ifdef DCT_TRANSPOSE_OVF_EN
  logic              o_ovf;
`endif

  int total = 0;
  int bad   = 0;

  dct_transpose #(.W(8)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .i_stb (i_stb),
    .i_D0  (i_D0), .i_D1 (i_D1), .i_D2 (i_D2), .i_D3 (i_D3),
    .i_D4  (i_D4), .i_D5 (i_D5), .i_D6 (i_D6), .i_D7 (i_D7),
    .o_stb (o_stb),
    .o_D0  (o_D0), .o_D1 (o_D1), .o_D2 (o_D2), .o_D3 (o_D3),
    .o_D4  (o_D4), .o_D5 (o_D5), .o_D6 (o_D6), .o_D7 (o_D7)
`ifdef DCT_TRANSPOSE_OVF_EN
    ,
    .o_ovf (o_ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Element (row r, col c) of block b for each stimulus pattern.
  function automatic logic [7:0] elem(input int pat, input int b, input int r, input int c);
    case (pat)
      0:       return 8'(16 * r + c);
      1:       return 8'(37 * b + 16 * r + c);
      2:       return (((r + c) % 2) == 1) ? 8'h7F : 8'h80;
      default: return 8'((8 * r + c) ^ 8'hA5);
    endcase
  endfunction

  // Expected column k: o_Dj = element (row j, col k).
  function automatic logic [63:0] col_exp(input int pat, input int b, input int k);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = elem(pat, b, j, k);
    return v;
  endfunction

  function automatic logic [63:0] out_bus();
    return {o_D7, o_D6, o_D5, o_D4, o_D3, o_D2, o_D1, o_D0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_row(input int pat, input int b, input int r);
    i_stb = 1'b1;
    i_D0 = elem(pat, b, r, 0); i_D1 = elem(pat, b, r, 1);
    i_D2 = elem(pat, b, r, 2); i_D3 = elem(pat, b, r, 3);
    i_D4 = elem(pat, b, r, 4); i_D5 = elem(pat, b, r, 5);
    i_D6 = elem(pat, b, r, 6); i_D7 = elem(pat, b, r, 7);
  endtask

  task automatic put_idle();
    i_stb = 1'b0;
  endtask

  // Back-to-back rows; column (t-8) of the stream must appear at iteration t.
  task automatic stream(input string name, input int pat, input int nblk);
    for (int t = 0; t < nblk * 8 + 8; t++) begin
      if (t < nblk * 8) put_row(pat, t / 8, t % 8);
      else              put_idle();
      @(negedge clk);
      if (t < 8) begin
        check($sformatf("%s_stb_pre%0d", name, t), 64'(o_stb), 64'd0);
      end else begin
        check($sformatf("%s_stb_t%0d", name, t), 64'(o_stb), 64'd1);
        check($sformatf("%s_col_b%0d_k%0d", name, (t - 8) / 8, (t - 8) % 8),
              out_bus(), col_exp(pat, (t - 8) / 8, (t - 8) % 8));
      end
    end
    put_idle();
    @(negedge clk);
    check($sformatf("%s_stb_end", name), 64'(o_stb), 64'd0);
    check($sformatf("%s_hold", name), out_bus(), col_exp(pat, nblk - 1, 7));
  endtask

  initial begin
    rst_n = 1'b0;
    i_stb = 1'b0;
    {i_D0, i_D1, i_D2, i_D3, i_D4, i_D5, i_D6, i_D7} = '0;
    repeat (2) @(negedge clk);
    check("rst_stb", 64'(o_stb), 64'd0);
    check("rst_dat", out_bus(), 64'd0);
`ifdef DCT_TRANSPOSE_OVF_EN
    check("rst_ovf", 64'(o_ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single block, element c of row r = 16r+c.
    stream("single", 0, 1);

    // Eight blocks back to back: 64 gapless columns.
    stream("cont", 1, 8);
`ifdef DCT_TRANSPOSE_OVF_EN
    check("cont_ovf", 64'(o_ovf), 64'd0);
`endif

    // 24 consecutive rows: banks always free in time, nothing may be dropped.
    stream("rows24", 1, 3);
`ifdef DCT_TRANSPOSE_OVF_EN
    check("rows24_ovf", 64'(o_ovf), 64'd0);
`endif

    // Rows every 3rd cycle with extreme values -128 / 127.
    for (int r = 0; r < 8; r++) begin
      put_row(2, 0, r);
      @(negedge clk);
      check($sformatf("gap_stb_row%0d", r), 64'(o_stb), 64'd0);
      if (r < 7) begin
        for (int g = 0; g < 2; g++) begin
          put_idle();
          @(negedge clk);
          check($sformatf("gap_stb_idle%0d_%0d", r, g), 64'(o_stb), 64'd0);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      put_idle();
      @(negedge clk);
      check($sformatf("gap_stb_k%0d", k), 64'(o_stb), 64'd1);
      check($sformatf("gap_col_k%0d", k), out_bus(), col_exp(2, 0, k));
    end
    @(negedge clk);
    check("gap_stb_end", 64'(o_stb), 64'd0);
    check("gap_hold", out_bus(), col_exp(2, 0, 7));

    // Five rows of a block, then reset mid-cycle: outputs clear at once.
    for (int r = 0; r < 5; r++) begin
      put_row(3, 0, r);
      @(negedge clk);
    end
    put_idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stb", 64'(o_stb), 64'd0);
    check("midrst_dat", out_bus(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh block after reset: any leftover row would shift the output timing.
    stream("postrst", 3, 1);
`ifdef DCT_TRANSPOSE_OVF_EN
    check("final_ovf", 64'(o_ovf), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
